// File: rtl/calc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : calc_ctrl
// Purpose  : Two-key operand entry and launch controller for an external
//            arithmetic unit. Both pushbuttons are synchronized, debounced
//            and edge-detected. A 7-state FSM latches operands, checks the
//            one-hot operation select, launches the unit, waits for its
//            done strobe with a timeout, and drives a 16-bit display word.
// Ports    : clk        - sole clock, rising edge
//            rst_n      - asynchronous active-low reset
//            k_1, k_2   - raw active-low pushbuttons (operand A / operand B)
//            sw_val     - operand switches
//            op_sel     - one-hot operation switches
//            calc_done  - arithmetic unit done strobe
//            result     - arithmetic unit result (valid with calc_done)
//            reg_1/2    - latched operands A / B
//            op_code    - encoded operation (bit index of op_sel)
//            calc_start - one-cycle launch pulse
//            busy       - high while EXEC or WAIT
//            err        - high while in ERR
//            disp_val   - value for the 4-digit display driver
// Macro    : CALC_CTRL_AUTO_EN - when defined, a change of one-hot op_sel
//            while showing a result relaunches the computation.
// Revision : 1.0 - initial release
// ============================================================================
module calc_ctrl #(
  parameter int DEB_CYCLES = 50000,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        k_1,
  input  logic        k_2,
  input  logic [3:0]  sw_val,
  input  logic [3:0]  op_sel,
  input  logic        calc_done,
  input  logic [7:0]  result,
  output logic [3:0]  reg_1,
  output logic [3:0]  reg_2,
  output logic [1:0]  op_code,
  output logic        calc_start,
  output logic        busy,
  output logic        err,
  output logic [15:0] disp_val
);

  localparam int DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int TMO_W = 8;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GOT_A = 3'd1,
    GOT_B = 3'd2,
    EXEC  = 3'd3,
    WAIT  = 3'd4,
    SHOW  = 3'd5,
    ERR   = 3'd6
  } state_t;

  // --------------------------------------------------------------------------
  // Reset release synchronizer: flops are asynchronously cleared by rst_n,
  // but the FSM only acts on key events once release has crossed into clk.
  // --------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign run = rst_sync_q[1];

  // --------------------------------------------------------------------------
  // Key conditioning: 2-flop synchronizer, stable-count debouncer, press
  // pulse on the debounced high-to-low transition. Index 0 is k_1.
  // --------------------------------------------------------------------------
  logic [1:0] key_raw;
  logic [1:0] press;

  assign key_raw = {k_2, k_1};

  for (genvar i = 0; i < 2; i++) begin : g_key
    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      // Any sample equal to the current level restarts the count, so the
      // level only moves after DEB_CYCLES consecutive opposite samples.
      if (sync_q[1] != level_q) begin
        if (cnt_q == DEB_LAST) level_d = sync_q[1];
        else                   cnt_d   = cnt_q + 1'b1;
      end
      press_d = level_q & ~level_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q  <= 2'b11;
        level_q <= 1'b1;
        cnt_q   <= '0;
        press_q <= 1'b0;
      end else begin
        sync_q  <= {sync_q[0], key_raw[i]};
        level_q <= level_d;
        cnt_q   <= cnt_d;
        press_q <= press_d;
      end
    end

    assign press[i] = press_q;
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [3:0]       reg_1_q, reg_1_d;
  logic [3:0]       reg_2_q, reg_2_d;
  logic [1:0]       op_code_q, op_code_d;
  logic [7:0]       res_q, res_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             calc_start_q, calc_start_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [15:0]      disp_q, disp_d;

  logic             ev_1, ev_2;
  logic             sel_onehot;
  logic [1:0]       sel_enc;

  // k_1 has priority: a simultaneous k_2 event is dropped.
  assign ev_1 = press[0] & run;
  assign ev_2 = press[1] & run & ~press[0];

  assign sel_onehot = (op_sel != 4'd0) && ((op_sel & (op_sel - 4'd1)) == 4'd0);

  always_comb begin
    sel_enc = 2'd0;
    case (op_sel)
      4'b0010: sel_enc = 2'd1;
      4'b0100: sel_enc = 2'd2;
      4'b1000: sel_enc = 2'd3;
      default: sel_enc = 2'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    reg_1_d   = reg_1_q;
    reg_2_d   = reg_2_q;
    op_code_d = op_code_q;
    res_d     = res_q;
    tmo_d     = tmo_q;

    case (state_q)
      IDLE, ERR: begin
        if (ev_1) begin
          reg_1_d = sw_val;
          state_d = GOT_A;
        end
      end
      GOT_A: begin
        if (ev_1) begin
          reg_1_d = sw_val;
          state_d = GOT_A;
        end else if (ev_2) begin
          reg_2_d = sw_val;
          state_d = GOT_B;
        end
      end
      GOT_B: begin
        if (sel_onehot) begin
          op_code_d = sel_enc;
          state_d   = EXEC;
        end else begin
          state_d = ERR;
        end
      end
      EXEC: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // The done strobe is checked first so it wins over a same-cycle
        // timeout.
        if (calc_done) begin
          res_d   = result;
          state_d = SHOW;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      SHOW: begin
        if (ev_1) begin
          reg_1_d = sw_val;
          state_d = GOT_A;
        end
`ifdef CALC_CTRL_AUTO_EN
        else if (sel_onehot && (sel_enc != op_code_q)) begin
          op_code_d = sel_enc;
          state_d   = EXEC;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so that their registered
    // copies line up with the state register.
    calc_start_d = (state_d == EXEC);
    busy_d       = (state_d == EXEC) || (state_d == WAIT);
    err_d        = (state_d == ERR);
    case (state_d)
      SHOW:    disp_d = {reg_1_d, reg_2_d, res_d};
      ERR:     disp_d = 16'hEEEE;
      default: disp_d = {reg_1_d, reg_2_d, 8'h00};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      reg_1_q      <= '0;
      reg_2_q      <= '0;
      op_code_q    <= '0;
      res_q        <= '0;
      tmo_q        <= '0;
      calc_start_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      disp_q       <= 16'h0000;
    end else begin
      state_q      <= state_d;
      reg_1_q      <= reg_1_d;
      reg_2_q      <= reg_2_d;
      op_code_q    <= op_code_d;
      res_q        <= res_d;
      tmo_q        <= tmo_d;
      calc_start_q <= calc_start_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      disp_q       <= disp_d;
    end
  end

  assign reg_1      = reg_1_q;
  assign reg_2      = reg_2_q;
  assign op_code    = op_code_q;
  assign calc_start = calc_start_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign disp_val   = disp_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_calc_ctrl
// Purpose  : Self-checking bench for calc_ctrl (DEB_CYCLES=4, TIMEOUT=8).
//            Stimulus pushes expected launches and completions into a
//            scoreboard queue; a monitor pops them when the DUT presents a
//            launch pulse, a completion (busy falling) or an op-select error.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_ctrl;

  localparam int DEB = 4;
  localparam int TMO = 8;

  logic        clk;
  logic        rst_n;
  logic        k_1, k_2;
  logic [3:0]  sw_val, op_sel;
  logic        calc_done;
  logic [7:0]  result;
  logic [3:0]  reg_1, reg_2;
  logic [1:0]  op_code;
  logic        calc_start, busy, err;
  logic [15:0] disp_val;

  calc_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .k_1(k_1), .k_2(k_2), .sw_val(sw_val),
    .op_sel(op_sel), .calc_done(calc_done), .result(result),
    .reg_1(reg_1), .reg_2(reg_2), .op_code(op_code), .calc_start(calc_start),
    .busy(busy), .err(err), .disp_val(disp_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard entry kinds: 0 launch, 1 completion, 2 op-select error
  typedef struct {
    int          kind;
    logic [3:0]  r1, r2;
    logic [1:0]  opc;
    logic [15:0] disp;
    logic        er;
    int          lat;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_launch = 0;
  int r1_changes = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- arithmetic unit responder ----------------
  int         resp_delay = 0;
  logic [7:0] resp_result = 8'h00;
  int         man_req = 0;

  initial begin : responder
    int cnt;
    int man_ack;
    cnt = 0;
    man_ack = 0;
    calc_done = 1'b0;
    result = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      calc_done = 1'b0;
      if (!rst_n) cnt = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          calc_done = 1'b1;
          result = resp_result;
        end
      end
      if (rst_n && calc_start && resp_delay > 0) cnt = resp_delay;
      if (man_req != man_ack) begin
        man_ack = man_req;
        calc_done = 1'b1;
        result = 8'hA5;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic       pb, pe;
    logic [3:0] pr1;
    int         lc;
    exp_t       e;
    pb = 0; pe = 0; pr1 = 0; lc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pb = 0; pe = 0; pr1 = 4'h0;
        continue;
      end
      if (reg_1 !== pr1) r1_changes++;
      pr1 = reg_1;
      if (calc_start) begin
        n_launch++;
        lc = cyc;
        if (sb.size() == 0) chk("unexpected_launch", 1, 0);
        else begin
          e = sb.pop_front();
          chk("launch_kind", 0, e.kind);
          chk("launch_ops", {reg_1, reg_2, op_code}, {e.r1, e.r2, e.opc});
        end
      end
      if (pb && !busy) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("done_kind", 1, e.kind);
          chk("done_disp", disp_val, e.disp);
          chk("done_err", err, e.er);
          chk("done_latency", cyc - lc, e.lat);
        end
      end else if (!pb && err && !pe) begin
        if (sb.size() == 0) chk("unexpected_err", 1, 0);
        else begin
          e = sb.pop_front();
          chk("badop_kind", 2, e.kind);
          chk("badop_disp", disp_val, e.disp);
        end
      end
      pb = busy;
      pe = err;
    end
  end

  // ---------------- reference model and stimulus ----------------
  logic [3:0] m_a = 4'h0;
  logic [3:0] m_b = 4'h0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit second, input logic [3:0] v);
    sw_val = v;
    if (second) k_2 = 1'b0; else k_1 = 1'b0;
    tick(10);
    k_1 = 1'b1;
    k_2 = 1'b1;
    tick(10);
  endtask

  function automatic logic [1:0] sel_index(input logic [3:0] s);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (s[i]) r = 2'(i);
    return r;
  endfunction

  // Pushes what an operation with these operands must produce.
  task automatic expect_op(input logic [3:0] sel, input int dly, input logic [7:0] res);
    exp_t e;
    e = '{kind: 0, r1: m_a, r2: m_b, opc: 2'd0, disp: 16'h0, er: 1'b0, lat: 0};
    if ($countones(sel) == 1) begin
      e.opc = sel_index(sel);
      sb.push_back(e);
      e.kind = 1;
      if (dly >= 1 && dly <= TMO) begin
        e.disp = {m_a, m_b, res}; e.er = 1'b0; e.lat = dly + 1;
      end else begin
        e.disp = 16'hEEEE; e.er = 1'b1; e.lat = TMO + 1;
      end
      sb.push_back(e);
    end else begin
      e.kind = 2;
      e.disp = 16'hEEEE;
      sb.push_back(e);
    end
  endtask

  task automatic op_first(input logic [3:0] a);
    m_a = a;
    press(1'b0, a);
  endtask

  task automatic op_second(input logic [3:0] b, input logic [3:0] sel,
                           input int dly, input logic [7:0] res);
    m_b = b;
    resp_delay = dly;
    resp_result = res;
    op_sel = sel;
    expect_op(sel, dly, res);
    press(1'b1, b);
    tick(8);
  endtask

  initial begin : stim
    int l0, c0;
    bit seen;
    logic [3:0] sel;
    rst_n = 1'b0; k_1 = 1'b1; k_2 = 1'b1; sw_val = 4'h0; op_sel = 4'h0;
    tick(3);
    chk("reset_outputs", {reg_1, reg_2, op_code, calc_start, busy, err, disp_val},
        32'h0);
    rst_n = 1'b1;
    tick(5);

    // k_2 in IDLE is ignored
    l0 = n_launch;
    press(1'b1, 4'h9);
    chk("idle_k2_reg2", reg_2, 4'h0);
    chk("idle_k2_nolaunch", n_launch - l0, 0);

    // Basic operation: 3, 5, op 0, done two cycles after launch
    l0 = n_launch;
    op_first(4'h3);
    op_second(4'h5, 4'b0001, 2, 8'h08);
    chk("basic_disp", disp_val, 16'h3508);
    chk("basic_opcode", op_code, 2'd0);
    chk("basic_one_launch", n_launch - l0, 1);

    // Spurious calc_done outside WAIT
    man_req++;
    tick(4);
    chk("stray_done_disp", disp_val, 16'h3508);

    // Timeout boundary: done on 8th WAIT cycle wins, 9th is too late, none
    op_first(4'h1); op_second(4'h2, 4'b0010, TMO, 8'h77);
    op_first(4'h4); op_second(4'h6, 4'b1000, TMO + 1, 8'h66);
    chk("late_done_err", err, 1'b1);
    op_first(4'h7); op_second(4'h8, 4'b0100, 0, 8'h00);
    chk("timeout_disp", disp_val, 16'hEEEE);

    // Bad op select, then recovery with k_1
    op_first(4'hC); op_second(4'hD, 4'b0110, 1, 8'h11);
    chk("badop_err", err, 1'b1);
    chk("badop_disp_now", disp_val, 16'hEEEE);
    press(1'b0, 4'h2);
    m_a = 4'h2;
    chk("recover_reg1", reg_1, 4'h2);
    chk("recover_err", err, 1'b0);
    chk("recover_disp", disp_val, {4'h2, m_b, 8'h00});

    // Simultaneous k_1/k_2 in GOT_A: k_1 wins
    sw_val = 4'h7; k_1 = 1'b0; k_2 = 1'b0;
    tick(10); k_1 = 1'b1; k_2 = 1'b1; tick(10);
    m_a = 4'h7;
    chk("both_reg1", reg_1, 4'h7);
    chk("both_reg2_kept", reg_2, m_b);
    op_second(4'hB, 4'b0100, 3, 8'h3C);

    // k_1 press during WAIT is ignored; operation times out
    op_first(4'h5);
    m_b = 4'hF; resp_delay = 0; op_sel = 4'b0001;
    expect_op(4'b0001, 0, 8'h00);
    sw_val = 4'hF; k_2 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (calc_start) seen = 1'b1;
    end
    chk("wait_launch_seen", seen, 1'b1);
    sw_val = 4'h9; k_1 = 1'b0;
    tick(14); k_1 = 1'b1; k_2 = 1'b1; tick(10);
    chk("wait_k1_ignored", reg_1, 4'h5);
    chk("wait_k1_err", err, 1'b1);

    // Reset during WAIT aborts; later calc_done is not captured
    op_first(4'hA);
    m_b = 4'h3; resp_delay = 0; op_sel = 4'b0010;
    sb.push_back('{kind: 0, r1: 4'hA, r2: 4'h3, opc: 2'd1, disp: 16'h0, er: 1'b0, lat: 0});
    sw_val = 4'h3; k_2 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (calc_start) seen = 1'b1;
    end
    chk("rst_launch_seen", seen, 1'b1);
    tick(3);
    chk("rst_busy_before", busy, 1'b1);
    rst_n = 1'b0; k_2 = 1'b1;
    #2;
    chk("rst_async_outputs", {reg_1, reg_2, op_code, busy, err, disp_val}, 32'h0);
    tick(2);
    rst_n = 1'b1;
    m_a = 4'h0; m_b = 4'h0;
    tick(2);
    man_req++;
    tick(6);
    chk("rst_after_outputs", {reg_1, reg_2, op_code, calc_start, busy, err, disp_val},
        32'h0);
    tick(10);

    // Bouncing k_1: one event only, reg_1 loaded once
    c0 = r1_changes;
    sw_val = 4'hA;
    for (int i = 0; i < 5; i++) begin
      k_1 = 1'b0; tick(3); k_1 = 1'b1; tick(1);
    end
    sw_val = 4'h6; k_1 = 1'b0;
    tick(10); k_1 = 1'b1; tick(10);
    m_a = 4'h6;
    chk("bounce_reg1", reg_1, 4'h6);
    chk("bounce_loads", r1_changes - c0, 1);
    op_second(4'h1, 4'b1000, 4, 8'h99);

    // Randomized operations
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(0, 9) < 7) sel = 4'b0001 << $urandom_range(0, 3);
      else sel = 4'($urandom);
      op_first(4'($urandom));
      op_second(4'($urandom), sel, int'($urandom_range(1, 10)), 8'($urandom));
    end

    // op_sel change while showing a result
    op_first(4'h3); op_second(4'h4, 4'b0001, 2, 8'h21);
    l0 = n_launch;
`ifdef CALC_CTRL_AUTO_EN
    resp_delay = 3; resp_result = 8'h42;
    sb.push_back('{kind: 0, r1: 4'h3, r2: 4'h4, opc: 2'd2, disp: 16'h0, er: 1'b0, lat: 0});
    sb.push_back('{kind: 1, r1: 4'h3, r2: 4'h4, opc: 2'd2, disp: 16'h3442, er: 1'b0, lat: 4});
`endif
    op_sel = 4'b0100;
    tick(20);
`ifdef CALC_CTRL_AUTO_EN
    chk("auto_launches", n_launch - l0, 1);
    chk("auto_opcode", op_code, 2'd2);
`else
    chk("noauto_launches", n_launch - l0, 0);
    chk("noauto_opcode", op_code, 2'd0);
`endif

    for (int i = 0; i < 50 && sb.size() != 0; i++) tick(1);
    chk("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
